// File: rtl/usart_rx_frontend.sv
// Oversampling receive front-end for an 8251-style USART: synchroniser, 16x start-bit
// validation, 5-8 bit deserialiser with parity/framing/break status. Optional macro: USART_RX_MAJORITY_EN.
module usart_rx_frontend #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clken,
  input  logic       baud16_tick,
  input  logic       rx,
  input  logic       rx_enable,
  input  logic [1:0] char_length,
  input  logic       parity_en,
  input  logic       parity_even,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       break_det,
  output logic       rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef USART_RX_MAJORITY_EN
  localparam logic [3:0] DEC_TC = 4'd9;
`else
  localparam logic [3:0] DEC_TC = 4'd7;
`endif

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_prev_q;
  logic [3:0]             tc_q, tc_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [1:0]             len_q, len_d;
  logic                   par_en_q, par_en_d;
  logic                   par_even_q, par_even_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic [3:0]             high_cnt_q, high_cnt_d;
  logic                   break_q, break_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
`ifdef USART_RX_MAJORITY_EN
  logic                   s7_q, s7_d, s8_q, s8_d;
`endif

  logic       rxs, fall, dec, wrap, bit_val, par_exp;
  logic [2:0] last_bit;

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign fall     = rxs_prev_q & ~rxs;
  assign dec      = baud16_tick && (tc_q == DEC_TC);
  assign wrap     = baud16_tick && (tc_q == 4'd15);
  assign last_bit = 3'd4 + {1'b0, len_q};
  assign par_exp  = (^shift_q) ^ ~par_even_q;
`ifdef USART_RX_MAJORITY_EN
  assign bit_val  = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);
`else
  assign bit_val  = rxs;
`endif

  // Next-state logic; disabling the receiver overrides everything and drops any break hold.
  always_comb begin
    state_d    = state_q;
    tc_d       = tc_q;
    bit_cnt_d  = bit_cnt_q;
    len_d      = len_q;
    par_en_d   = par_en_q;
    par_even_d = par_even_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    high_cnt_d = high_cnt_q;
    break_d    = break_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
`ifdef USART_RX_MAJORITY_EN
    s7_d = s7_q;
    s8_d = s8_q;
    if (baud16_tick && tc_q == 4'd7) s7_d = rxs;
    if (baud16_tick && tc_q == 4'd8) s8_d = rxs;
`endif
    if (baud16_tick) tc_d = tc_q + 4'd1;

    if (!rx_enable) begin
      state_d    = IDLE;
      break_d    = 1'b0;
      high_cnt_d = '0;
    end else begin
      // Break holds until the line has been idle-high for a full bit time.
      if (break_q) begin
        if (!rxs) begin
          high_cnt_d = '0;
        end else if (baud16_tick) begin
          if (high_cnt_q == 4'd15) begin
            break_d    = 1'b0;
            high_cnt_d = '0;
          end else begin
            high_cnt_d = high_cnt_q + 4'd1;
          end
        end
      end
      case (state_q)
        IDLE: begin
          if (fall && !break_q) begin
            state_d    = START;
            tc_d       = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            par_bit_d  = 1'b0;
            len_d      = char_length;
            par_en_d   = parity_en;
            par_even_d = parity_even;
          end
        end
        START: begin
          if (dec && bit_val) state_d = IDLE;
          else if (wrap)      state_d = DATA;
        end
        DATA: begin
          if (dec) shift_d[bit_cnt_q] = bit_val;
          if (wrap) begin
            if (bit_cnt_q == last_bit) state_d = par_en_q ? PARITY : STOP;
            else                       bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          if (dec)  par_bit_d = bit_val;
          if (wrap) state_d = STOP;
        end
        STOP: begin
          // Leave at mid-stop so a start edge in the second half of the stop bit is seen.
          if (dec) begin
            state_d    = IDLE;
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
            perr_d     = par_en_q & (par_bit_q ^ par_exp);
            ferr_d     = ~bit_val;
            if (shift_q == 8'd0 && !(par_en_q && par_bit_q) && !bit_val) begin
              break_d    = 1'b1;
              high_cnt_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      tc_q       <= '0;
      bit_cnt_q  <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      high_cnt_q <= '0;
      break_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef USART_RX_MAJORITY_EN
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
`endif
    end else if (clken) begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      tc_q       <= tc_d;
      bit_cnt_q  <= bit_cnt_d;
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      par_even_q <= par_even_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      high_cnt_q <= high_cnt_d;
      break_q    <= break_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
`ifdef USART_RX_MAJORITY_EN
      s7_q       <= s7_d;
      s8_q       <= s8_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = perr_q;
  assign framing_err = ferr_q;
  assign break_det   = break_q;
  assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_usart_rx_frontend.sv
// Directed self-checking bench for usart_rx_frontend: a table of character frames plus
// hand-written sequences for glitch, break, back-to-back, disable and reset cases.
module tb_usart_rx_frontend;

  localparam int BIT_CYC = 64;
`ifdef USART_RX_MAJORITY_EN
  localparam int LAT_MIN = 616;
`else
  localparam int LAT_MIN = 608;
`endif
  localparam int LAT_MAX = LAT_MIN + 3;

  logic       clk = 1'b0;
  logic       reset_n, clken, baud16_tick, rx, rx_enable;
  logic [1:0] char_length;
  logic       parity_en, parity_even;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, framing_err, break_det, rx_busy;

  typedef struct {
    logic [7:0] data;
    logic [1:0] len;
    logic       pe;
    logic       pev;
    logic       bad;
    logic       stopv;
    logic [7:0] expData;
    logic       expPerr;
    logic       expFerr;
    logic       expBrk;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
    int         cyc;
  } strobe_t;

  vec_t    vecs[8];
  strobe_t strobeQ[$];
  strobe_t s;
  int      checks = 0;
  int      errors = 0;
  int      cycleCnt = 0;
  int      lastStartCycle = 0;
  int      tickPhase = 0;
  int      diff;

  usart_rx_frontend #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .baud16_tick(baud16_tick),
    .rx(rx), .rx_enable(rx_enable), .char_length(char_length),
    .parity_en(parity_en), .parity_even(parity_even), .rx_data(rx_data),
    .rx_valid(rx_valid), .parity_err(parity_err), .framing_err(framing_err),
    .break_det(break_det), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // 16x tick every fourth clock
  initial begin
    baud16_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tickPhase   = (tickPhase + 1) % 4;
      baud16_tick = (tickPhase == 0);
    end
  end

  always @(negedge clk) begin
    if (reset_n && rx_valid) begin
      strobeQ.push_back('{d: rx_data, pe: parity_err, fe: framing_err, bk: break_det, cyc: cycleCnt});
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic holdBit(input logic b);
    rx = b;
    repeat (BIT_CYC) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic [1:0] len, input logic pe,
                           input logic pev, input logic bad, input logic stopv);
    logic [7:0] mask;
    logic       p;
    mask = 8'hFF >> (3 - len);
    p    = ^(d & mask);
    if (!pev) p = ~p;
    if (bad)  p = ~p;
    lastStartCycle = cycleCnt;
    holdBit(1'b0);
    for (int i = 0; i < 5 + len; i++) holdBit(d[i]);
    if (pe) holdBit(p);
    holdBit(stopv);
    rx = 1'b1;
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    char_length = v.len;
    parity_en   = v.pe;
    parity_even = v.pev;
    strobeQ.delete();
    sendFrame(v.data, v.len, v.pe, v.pev, v.bad, v.stopv);
    holdBit(1'b1);
    holdBit(1'b1);
    checkOutput($sformatf("v%0d_strobes", idx), strobeQ.size(), 1);
    if (strobeQ.size() > 0) begin
      s = strobeQ.pop_front();
      checkOutput($sformatf("v%0d_data", idx), {24'd0, s.d}, {24'd0, v.expData});
      checkOutput($sformatf("v%0d_parity_err", idx), {31'd0, s.pe}, {31'd0, v.expPerr});
      checkOutput($sformatf("v%0d_framing_err", idx), {31'd0, s.fe}, {31'd0, v.expFerr});
      checkOutput($sformatf("v%0d_break", idx), {31'd0, s.bk}, {31'd0, v.expBrk});
      if (idx == 0) begin
        diff = s.cyc - lastStartCycle;
        checks++;
        if (diff < LAT_MIN || diff > LAT_MAX) begin
          errors++;
          $display("[TB] FAIL v0_latency: got %0d cycles expected %0d..%0d", diff, LAT_MIN, LAT_MAX);
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h41, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h15, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h5A, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h07, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0; clken = 1'b1; rx = 1'b1; rx_enable = 1'b1;
    char_length = 2'b11; parity_en = 1'b0; parity_even = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    checkOutput("reset_break", {31'd0, break_det}, 32'd0);
    checkOutput("reset_errs", {30'd0, parity_err, framing_err}, 32'd0);
    reset_n = 1'b1;
    holdBit(1'b1);

    for (int i = 0; i < 8; i++) applyStimulus(i);

    // Short low glitch: start is rejected at the sample point
    char_length = 2'b11; parity_en = 1'b0;
    strobeQ.delete();
    rx = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("glitch_busy_rise", {31'd0, rx_busy}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("glitch_busy_drop", {31'd0, rx_busy}, 32'd0);
    holdBit(1'b1);
    checkOutput("glitch_no_strobe", strobeQ.size(), 0);

    // Line held low for 30 bit times: a single break character
    repeat (30) holdBit(1'b0);
    checkOutput("break_strobes", strobeQ.size(), 1);
    if (strobeQ.size() > 0) begin
      s = strobeQ.pop_front();
      checkOutput("break_data", {24'd0, s.d}, 32'd0);
      checkOutput("break_ferr", {31'd0, s.fe}, 32'd1);
      checkOutput("break_flag_at_strobe", {31'd0, s.bk}, 32'd1);
    end
    rx = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    checkOutput("break_held", {31'd0, break_det}, 32'd1);
    repeat (64) @(posedge clk);
    #1;
    checkOutput("break_cleared", {31'd0, break_det}, 32'd0);
    holdBit(1'b1);
    checkOutput("break_no_more_strobes", strobeQ.size(), 0);

    // Back-to-back frames with a single stop bit
    strobeQ.delete();
    sendFrame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    sendFrame(8'hAA, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    holdBit(1'b1);
    checkOutput("b2b_strobes", strobeQ.size(), 2);
    if (strobeQ.size() >= 2) begin
      s = strobeQ.pop_front();
      checkOutput("b2b_first", {24'd0, s.d}, 32'h55);
      s = strobeQ.pop_front();
      checkOutput("b2b_second", {24'd0, s.d}, 32'hAA);
      checkOutput("b2b_second_ferr", {31'd0, s.fe}, 32'd0);
    end

    // Receiver disabled mid-frame
    strobeQ.delete();
    holdBit(1'b0);
    holdBit(1'b1);
    holdBit(1'b0);
    checkOutput("abort_busy_before", {31'd0, rx_busy}, 32'd1);
    rx_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_busy_after", {31'd0, rx_busy}, 32'd0);
    repeat (9) holdBit(1'b1);
    checkOutput("abort_no_strobe", strobeQ.size(), 0);
    rx_enable = 1'b1;
    holdBit(1'b1);

    // Asynchronous reset mid-frame
    holdBit(1'b0);
    holdBit(1'b1);
    checkOutput("rst_busy_before", {31'd0, rx_busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    checkOutput("rst_flags", {28'd0, rx_valid, parity_err, framing_err, break_det}, 32'd0);
    @(posedge clk);
    #1;
    rx = 1'b1;
    reset_n = 1'b1;
    repeat (4) holdBit(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usart_rx_frontend.md
# usart_rx_frontend

Oversampling asynchronous receiver front-end for the 8251-compatible USART. It sits between the external RX pin and the USART core's receive buffer. It synchronises the line, detects and validates start bits on a 16x baud tick, and deserialises 5–8 data bits with optional parity. It presents each character to the core as a one-cycle strobe with parity, framing and break status.

## Interface
Parameters:
- SYNC_STAGES, 2, number of input synchroniser flops on `rx` (minimum 2).

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous active-low reset; all state clears immediately on assertion.
- clken  in  1  clock enable; all state advances only when high.
- baud16_tick  in  1  one-`clken`-cycle pulse at 16x bit rate.
- rx  in  1  raw serial line; idle high.
- rx_enable  in  1  receiver enable (command bit RxE).
- char_length  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- parity_en  in  1  parity bit present.
- parity_even  in  1  1=even, 0=odd parity.
- rx_data  out  8  received character, LSB first; unused upper bits are 0; reset 0.
- rx_valid  out  1  one-`clken`-cycle strobe; `rx_data` and the error flags are valid with it; reset 0.
- parity_err  out  1  parity mismatch for the strobed character; reset 0.
- framing_err  out  1  stop bit sampled low; reset 0.
- break_det  out  1  level; reset 0.
- rx_busy  out  1  high from start-bit detect until the frame ends or is aborted; reset 0.

## Operation
- Synchroniser: `rx` passes through SYNC_STAGES flops (on `clken`) to give `rxs`. The previous value of `rxs` is kept for edge detection.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE → START: on a falling edge of `rxs` while `rx_enable`=1.
  - Clear the 4-bit tick counter `tc`.
  - Latch `char_length`, `parity_en` and `parity_even`. Mode changes mid-frame have no effect.
- `tc` increments on each `baud16_tick` and wraps 15→0. Bit boundaries are at the wrap.
- Sample point: the bit value is decided when `tc`=7.
- START: if the decided value is 1, it is a false start; return to IDLE with no strobe. Otherwise go to DATA at the next wrap.
- DATA: shift the decided value into bit position `n` (n = 0 … len-1).
  - After the last bit, go to PARITY if `parity_en`=1, else go to STOP.
- PARITY: compare the received bit against the expected value.
  - Expected = XOR of data bits for even parity; its inverse for odd parity.
- STOP: at the decision point, on the same `clken` cycle:
  - Register the outputs; `rx_valid` pulses on the following `clken` cycle.
  - `framing_err` = NOT(stop bit).
  - Return to IDLE immediately, without waiting for the end of the stop bit, so a start edge in the second half of the stop bit is accepted.
- Break: `break_det` sets when a frame completes with every data bit, the parity bit and the stop bit all 0.
  - It stays high until `rxs` has been 1 for a full bit time (16 ticks).
  - While `break_det` is high, no new start is accepted.
- Error flags are per-character: they are updated with each strobe and hold until the next one.
- `rx_enable` falling mid-frame: abort to IDLE next cycle, no strobe, `rx_busy` low. `break_det` clears.

## Timing
- Pin-to-`rxs` latency: SYNC_STAGES `clken` cycles.
- Start detect: `rx_busy` rises on the `clken` cycle after the falling edge of `rxs`.
- Strobe: `rx_valid` is high for exactly one `clken` cycle, one cycle after the STOP decision tick.
  - Nominal distance from the start edge is (1 + len + parity + 0.5) × 16 ticks.
- `rx_busy` falls in the same cycle `rx_valid` rises.
- `baud16_tick` with `clken`=0 is ignored.
- Back-to-back frames with 1 stop bit are received with no loss.
- Reset during a frame: outputs go to their reset values asynchronously; the interrupted character is lost.

## Configuration
- `USART_RX_MAJORITY_EN` defined:
  - The bit value is the 2-of-3 majority of `rxs` at `tc`=7, 8 and 9, decided at `tc`=9.
  - The strobe moves 2 ticks later.
  - Start validation uses the same majority.
- Not defined: single sample of `rxs` at `tc`=7. No extra sample flops are built.

## Test plan
- 8N1, byte 0x A5, 16 ticks/bit -> one `rx_valid`, `rx_data`=0xA5, parity_err=0, framing_err=0, strobe 152 ticks after the start edge (+2 cycles sync).
- 7E1 with the parity bit forced wrong for 0x41 -> `rx_data`=0x41, parity_err=1. 5O1 with 0x15 and correct parity -> `rx_data`=0x15, parity_err=0.
- Low glitch of 4 ticks on idle line -> rx_busy pulses, then drops at `tc`=7; no `rx_valid`.
- 8N1 0x3C with the stop bit held low, line then high -> framing_err=1, break_det=0.
- Line held low for 30 bit times -> one strobe with `rx_data`=0, framing_err=1, break_det=1; break_det clears 16 ticks after the line returns high; no further strobes.
- Two back-to-back frames 0x55, 0xAA -> both strobed; deassert `rx_enable` mid-third frame -> no strobe, rx_busy=0; assert `reset_n` low mid-frame -> all outputs 0 immediately.
